// File: rtl/acc_window_sampler.sv
// Window controller for a downstream accumulator: clears, accumulates over 2^WINLOG2 cycles,
// and presents each window mean through a valid/ready register. Define ACC_WINDOW_ROUND_EN for round-half-up.
module acc_window_sampler #(
  parameter int BITWIDTH = 32,
  parameter int WINLOG2  = 4
) (
  input  logic                iClk,
  input  logic                iRstN,
  input  logic                iStart,
  input  logic                iStop,
  input  logic [BITWIDTH:0]   iAccData,
  output logic                oAccEn,
  output logic                oAccClr,
  output logic [BITWIDTH:0]   oData,
  output logic                oValid,
  input  logic                iReady,
  output logic                oBusy,
  output logic                oOverrun
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_ACC    = 2'd2,
    ST_SAMPLE = 2'd3
  } state_t;

  localparam logic [WINLOG2-1:0] CNT_LAST = '1;
  localparam logic [WINLOG2-1:0] CNT_ONE  = WINLOG2'(1);

  state_t              state_r;
  logic [WINLOG2-1:0]  win_cnt_r;
  logic                stop_pend_r;
  logic [BITWIDTH:0]   data_r;
  logic                valid_r;
  logic                overrun_r;

  logic [BITWIDTH:0]   mean_s;
  logic                capture_s;
  logic                start_ok_s;

`ifdef ACC_WINDOW_ROUND_EN
  localparam logic [BITWIDTH+1:0] HALF_LSB = (BITWIDTH+2)'(1) << (WINLOG2 - 1);
  logic [BITWIDTH+1:0] round_sum_s;
`endif

  // Mean of the completed window plus capture/start qualifiers
  always_comb begin
`ifdef ACC_WINDOW_ROUND_EN
    round_sum_s = ({1'b0, iAccData} + HALF_LSB) >> WINLOG2;
    mean_s      = round_sum_s[BITWIDTH:0];
`else
    mean_s      = iAccData >> WINLOG2;
`endif
    capture_s  = (state_r == ST_SAMPLE);
    start_ok_s = (state_r == ST_IDLE) && iStart && !iStop;
  end

  // Window sequencing FSM; a stop is only honoured at the end of a full window
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_r     <= ST_IDLE;
      win_cnt_r   <= '0;
      stop_pend_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          stop_pend_r <= 1'b0;
          if (start_ok_s) begin
            state_r <= ST_CLEAR;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          win_cnt_r <= '0;
          state_r   <= ST_ACC;
          if (iStop) stop_pend_r <= 1'b1;
        end
        ST_ACC: begin
          win_cnt_r <= win_cnt_r + CNT_ONE;
          if (iStop) stop_pend_r <= 1'b1;
          if (win_cnt_r == CNT_LAST) begin
            state_r <= ST_SAMPLE;
          end else begin
            state_r <= ST_ACC;
          end
        end
        ST_SAMPLE: begin
          win_cnt_r <= '0;
          if (stop_pend_r || iStop) begin
            state_r     <= ST_IDLE;
            stop_pend_r <= 1'b0;
          end else begin
            state_r <= ST_ACC;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          win_cnt_r   <= '0;
          stop_pend_r <= 1'b0;
        end
      endcase
    end
  end

  // Result register with valid/ready handshake and sticky overrun
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      data_r    <= '0;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      if (capture_s) begin
        data_r  <= mean_s;
        valid_r <= 1'b1;
        if (valid_r && !iReady) overrun_r <= 1'b1;
      end else if (valid_r && iReady) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
      if (start_ok_s) overrun_r <= 1'b0;
    end
  end

  assign oAccEn   = (state_r == ST_ACC);
  assign oAccClr  = (state_r == ST_CLEAR) || (state_r == ST_SAMPLE);
  assign oBusy    = (state_r != ST_IDLE);
  assign oData    = data_r;
  assign oValid   = valid_r;
  assign oOverrun = overrun_r;

endmodule
